x_micro_scope_dump: RTL and testbench
=====================================

# x_micro_scope_dump

Read-side sequencer for the micro scope capture RAM. It arms a capture on request and waits for the capture to finish. It then walks every RAM address through the scope's read port and streams each 32-bit sample out as bytes on a valid/ready byte interface, which normally feeds the UART transmitter. It sits between the micro scope and the host link and is the only master of the scope's `i_start`/`i_ren`/`i_raddr` inputs.

## Interface
- `DEPTH_LOG2`, default 11: capture RAM address width (2048 entries).
- `DATA_W`, default 32: sample width; must be a multiple of 8.
- `i_clk`, in, 1: single clock for all logic.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_trigger`, in, 1: request capture and dump; sampled only in IDLE.
- `o_busy`, out, 1: high from the cycle after an accepted trigger until the last byte is accepted.
- `o_done`, out, 1: one-cycle pulse in the cycle the last byte is accepted.
- `o_start`, out, 1: to scope `i_start`; one-cycle pulse.
- `i_scope_busy`, in, 1: from scope `o_busy`.
- `o_ren`, out, 1: to scope `i_ren`.
- `o_raddr`, out, DEPTH_LOG2: to scope `i_raddr`.
- `i_rdata`, in, DATA_W: from scope `o_data`; valid the cycle after `o_ren`.
- `o_tx_data`, out, 8: byte to transmitter.
- `o_tx_valid`, out, 1: byte valid.
- `i_tx_ready`, in, 1: transmitter accepts byte when high with `o_tx_valid`.

## Operation
- FSM states: IDLE, ARM, WAIT, READ, LATCH, SEND.
- **IDLE:** `o_busy`=0. When `i_trigger`=1, drive `o_start`=1 this cycle, clear the address counter, and go to ARM.
- **ARM:** wait one cycle for the scope's busy flag to register, then go to WAIT.
- **WAIT:** hold while `i_scope_busy`=1. When it is 0, go to READ.
- **READ:** `o_ren`=1 and `o_raddr`=addr for exactly one cycle, then go to LATCH.
- **LATCH:** load `i_rdata` into the word shift register, clear the byte count, then go to SEND.
- **SEND:**
  - `o_tx_valid`=1 and `o_tx_data`=shift[7:0]; little-endian, so byte 0 is bits 7:0.
  - On `o_tx_valid & i_tx_ready`: shift right by 8 and increment the byte count.
  - After byte DATA_W/8−1 is accepted: if addr == 2^DEPTH_LOG2−1, pulse `o_done` and go to IDLE; otherwise addr+1 and go to READ.
- **Handshake:** once `o_tx_valid` is raised, it and `o_tx_data` stay stable until accepted. `o_tx_valid` never drops without acceptance, except on reset.
- **Triggers:** `i_trigger` is ignored in every state except IDLE; no queuing.
- **Address counter:** DEPTH_LOG2 bits. Last-word detection is an explicit compare, not a wrap.
- **Reset mid-operation:** FSM returns to IDLE and a partial dump is abandoned. Host framing recovery is out of scope.

## Timing
- Reset values: `o_busy`, `o_done`, `o_start`, `o_ren`, `o_tx_valid` = 0; `o_raddr`, `o_tx_data` = 0.
- **Arm phase:**
  - Trigger at cycle T: `o_start` high at T, `o_busy` high from T+1.
  - The scope holds busy for 2^DEPTH_LOG2−1 cycles from T+1.
  - READ of address 0 occurs at T+2^DEPTH_LOG2+1 at the earliest.
- **Read path:** `o_ren` in cycle R, word latched at the end of R+1, first byte valid at R+2.
- **Throughput:** with `i_tx_ready` held high, each word takes 2+DATA_W/8 cycles (6 for 32-bit). A full default dump is 12288 cycles after WAIT exits.
- **Last word:** `o_done` coincides with acceptance of the last byte; `o_busy` falls the next cycle.
- A trigger arriving in the same cycle as `o_done` is ignored. A new trigger is accepted from the first IDLE cycle.
- `o_ren` is never asserted while `i_scope_busy`=1; the scope gates that read anyway.

## Structure
- Package `x_micro_scope_pkg` holds:
  - localparams `SCOPE_DEPTH_LOG2`=11 and `SCOPE_DATA_W`=32, shared with the scope;
  - the FSM state enum `dump_state_t`.
- Sub-module `x_micro_scope_dump_ser`: word-load, byte shift register, byte counter and valid/ready output stage, with a `last_byte` flag back to the FSM.
- Top level holds the FSM, address counter and scope-side signals.

## Test plan
- **Reset defaults:** reset asserted mid-SEND -> all outputs 0 next cycle; no `o_tx_valid` until a new trigger.
- **Full dump, ready high:**
  - Stimulus: scope model fills RAM with data[n] = 32'hA500_0000 | n; `i_tx_ready`=1; trigger.
  - Response: 8192 bytes in address order; first four bytes 00,00,00,A5; last four FF,07,00,A5.
  - `o_done` is a single pulse.
- **Backpressure:** `i_tx_ready` randomly low 50% of cycles -> identical byte stream; `o_tx_data` stable whenever valid is high and ready is low.
- **Trigger ignore:** pulse `i_trigger` during WAIT and during SEND -> exactly one `o_start` and one dump.
- **Back-to-back:** trigger in the `o_done` cycle is ignored; trigger one cycle later -> new `o_start` and a second complete dump.
- **Read-port check:** assert `o_ren` is never high while `i_scope_busy` is high, and `o_raddr` increments by exactly 1 per READ from 0 to 2047.

Source files
------------

// File: rtl/x_micro_scope_dump_pkg.sv
// Shared definitions for the micro scope and its dump sequencer.
//   SCOPE_DEPTH_LOG2 : capture RAM address width
//   SCOPE_DATA_W     : capture sample width (multiple of 8)
//   dump_state_t     : dump sequencer FSM states
package x_micro_scope_pkg;

    localparam int unsigned SCOPE_DEPTH_LOG2 = 11;
    localparam int unsigned SCOPE_DATA_W     = 32;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWait,
        StRead,
        StLatch,
        StSend
    } dump_state_t;

endpackage

// File: rtl/x_micro_scope_dump_if.sv
// Byte stream (valid/ready) between the dump sequencer and the host transmitter.
//   tx_data  : byte being offered
//   tx_valid : byte valid, held with tx_data until accepted
//   tx_ready : transmitter accepts when high together with tx_valid
//   master   : byte source (dump sequencer)
//   slave    : byte sink (transmitter)
interface x_micro_scope_dump_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/x_micro_scope_dump_ser.sv
// Word-to-byte serializer for the scope dump.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_load        : load i_word and start offering its bytes, LSB byte first
//   i_word        : sample word to serialize
//   i_tx_ready    : downstream ready
//   o_tx_data     : current byte
//   o_tx_valid    : byte valid, held until accepted
//   o_last_byte   : high in the cycle the final byte of the word is accepted
module x_micro_scope_dump_ser #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic              o_last_byte
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              w_accept;

    assign w_accept    = r_valid & i_tx_ready;
    assign o_last_byte = w_accept & (r_cnt == LAST_CNT);
    assign o_tx_data   = r_shift[7:0];
    assign o_tx_valid  = r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_shift <= r_shift >> 8;
            r_cnt   <= r_cnt + 1'b1;
            if (o_last_byte) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/x_micro_scope_dump.sv
// Read-side sequencer for the micro scope: arms a capture, waits for it to
// finish, then reads every RAM word and streams it out as little-endian bytes.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_trigger     : capture+dump request, honoured only when idle
//   o_busy        : dump in progress
//   o_done        : pulse with acceptance of the final byte
//   o_start       : capture start pulse to the scope
//   i_scope_busy  : scope capture in progress
//   o_ren/o_raddr : scope read port
//   i_rdata       : scope read data, valid the cycle after o_ren
//   tx            : byte stream source
module x_micro_scope_dump
    import x_micro_scope_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = SCOPE_DEPTH_LOG2,
    parameter int unsigned DATA_W     = SCOPE_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_trigger,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_start,
    input  logic                  i_scope_busy,
    output logic                  o_ren,
    output logic [DEPTH_LOG2-1:0] o_raddr,
    input  logic [DATA_W-1:0]     i_rdata,
    x_micro_scope_dump_if.master  tx
);

    dump_state_t           r_state;
    dump_state_t           w_next;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic                  w_last_addr;
    logic                  w_last_byte;
    logic                  w_load;

    // Explicit compare so the final word is detected without relying on wrap.
    assign w_last_addr = (r_addr == {DEPTH_LOG2{1'b1}});
    assign w_load      = (r_state == StLatch);
    assign o_raddr     = r_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  if (i_trigger) w_next = StArm;
            // One cycle for the scope's busy flag to appear.
            StArm:   w_next = StWait;
            StWait:  if (!i_scope_busy) w_next = StRead;
            StRead:  w_next = StLatch;
            StLatch: w_next = StSend;
            StSend: begin
                if (w_last_byte) begin
                    w_next = w_last_addr ? StIdle : StRead;
                end
            end
            default: w_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy  = 1'b1;
        o_start = 1'b0;
        o_ren   = 1'b0;
        o_done  = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy  = 1'b0;
                o_start = i_trigger;
            end
            StRead:  o_ren  = 1'b1;
            StSend:  o_done = w_last_byte & w_last_addr;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
        end else if ((r_state == StIdle) && i_trigger) begin
            r_addr <= '0;
        end else if ((r_state == StSend) && w_last_byte && !w_last_addr) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    x_micro_scope_dump_ser #(
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_word      (i_rdata),
        .i_tx_ready  (tx.tx_ready),
        .o_tx_data   (tx.tx_data),
        .o_tx_valid  (tx.tx_valid),
        .o_last_byte (w_last_byte)
    );

endmodule

// File: tb/tb_x_micro_scope_dump.sv
// Self-checking bench for x_micro_scope_dump with a behavioural scope model
// and a byte-stream scoreboard built from the RAM contents.
module tb_x_micro_scope_dump;
    import x_micro_scope_pkg::*;

    localparam int unsigned DL = SCOPE_DEPTH_LOG2;
    localparam int unsigned DW = SCOPE_DATA_W;
    localparam int unsigned NW = 1 << DL;
    localparam int unsigned BPW = DW / 8;
    localparam int unsigned NB = NW * BPW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger = 1'b0;
    logic          busy, done, start, ren, scope_busy;
    logic [DL-1:0] raddr;
    logic [DW-1:0] rdata;
    bit            bp_en = 1'b0;

    int passed = 0;
    int total = 0;

    x_micro_scope_dump_if tx_if ();

    x_micro_scope_dump #(
        .DEPTH_LOG2 (DL),
        .DATA_W     (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_trigger    (trigger),
        .o_busy       (busy),
        .o_done       (done),
        .o_start      (start),
        .i_scope_busy (scope_busy),
        .o_ren        (ren),
        .o_raddr      (raddr),
        .i_rdata      (rdata),
        .tx           (tx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scope model: busy for NW-1 cycles after start, registered read port.
    int unsigned   scope_cnt;
    logic [DW-1:0] mem [NW];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            scope_cnt <= 0;
            rdata     <= '0;
        end else begin
            if (start) scope_cnt <= NW - 1;
            else if (scope_cnt != 0) scope_cnt <= scope_cnt - 1;
            if (ren && scope_cnt == 0) rdata <= mem[raddr];
        end
    end
    assign scope_busy = (scope_cnt != 0);

    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tx_if.tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: collects accepted bytes and protocol observations.
    logic [7:0] byte_q[$];
    int start_cnt = 0, done_cnt = 0, ren_cnt = 0, raddr_err = 0, ren_busy_err = 0;
    int stab_err = 0, done_noacc_err = 0, busy_after_done_err = 0, valid_cycles = 0;
    int last_start_cyc = 0, first_ren_cyc = 0, first_valid_cyc = 0, last_done_cyc = 0;
    int exp_addr = 0;
    bit fv_pending = 0;

    initial begin : monitor
        logic       prev_hold;
        logic [7:0] prev_data;
        logic       prev_done;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_hold && (!tx_if.tx_valid || tx_if.tx_data !== prev_data)) stab_err++;
                if (prev_done && busy) busy_after_done_err++;
                if (tx_if.tx_valid) valid_cycles++;
                if (tx_if.tx_valid && tx_if.tx_ready) byte_q.push_back(tx_if.tx_data);
                if (start) begin
                    start_cnt++;
                    last_start_cyc = cyc;
                    exp_addr = 0;
                    fv_pending = 1'b1;
                end
                if (ren) begin
                    ren_cnt++;
                    if (scope_busy) ren_busy_err++;
                    if (raddr !== DL'(exp_addr)) raddr_err++;
                    if (raddr == '0) first_ren_cyc = cyc;
                    exp_addr++;
                end
                if (tx_if.tx_valid && fv_pending) begin
                    first_valid_cyc = cyc;
                    fv_pending = 1'b0;
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    if (!(tx_if.tx_valid && tx_if.tx_ready)) done_noacc_err++;
                end
                prev_hold = tx_if.tx_valid && !tx_if.tx_ready;
                prev_data = tx_if.tx_data;
                prev_done = done;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference stream: every RAM word in address order, least significant byte first.
    logic [7:0] exp_q[$];
    task automatic build_expected();
        exp_q.delete();
        for (int n = 0; n < NW; n++)
            for (int b = 0; b < BPW; b++)
                exp_q.push_back(mem[n][8*b +: 8]);
    endtask

    task automatic fill_pattern();
        for (int n = 0; n < NW; n++) mem[n] = 32'hA500_0000 | n;
    endtask

    task automatic fill_random();
        for (int n = 0; n < NW; n++) mem[n] = $urandom;
    endtask

    task automatic pulse_trigger();
        @(posedge clk);
        #2 trigger = 1'b1;
        @(posedge clk);
        #2 trigger = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int base, input int budget, output bit timeout);
        int n;
        n = 0;
        timeout = 1'b0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == base) timeout = 1'b1;
    endtask

    task automatic test_reset();
        int vc, sc, n, base;
        wait_cycles(3);
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++; if (start !== 1'b0) $display("FAIL rst_start: got %b want 0", start); else passed++;
        total++; if (ren !== 1'b0) $display("FAIL rst_ren: got %b want 0", ren); else passed++;
        total++; if (tx_if.tx_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", tx_if.tx_valid); else passed++;
        total++; if (raddr !== '0) $display("FAIL rst_raddr: got %0h want 0", raddr); else passed++;
        total++; if (tx_if.tx_data !== 8'h00) $display("FAIL rst_data: got %0h want 0", tx_if.tx_data); else passed++;
        @(posedge clk);
        #2 rst = 1'b0;

        // Abort a dump mid-SEND.
        fill_pattern();
        base = byte_q.size();
        pulse_trigger();
        n = 0;
        while (byte_q.size() < base + 3 && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++; if (byte_q.size() < base + 3) $display("FAIL rst_reach_send: got %0d bytes want >=3", byte_q.size() - base); else passed++;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else passed++;
        total++; if (ren !== 1'b0) $display("FAIL midrst_ren: got %b want 0", ren); else passed++;
        total++; if (tx_if.tx_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", tx_if.tx_valid); else passed++;
        total++; if (raddr !== '0) $display("FAIL midrst_raddr: got %0h want 0", raddr); else passed++;
        total++; if (tx_if.tx_data !== 8'h00) $display("FAIL midrst_data: got %0h want 0", tx_if.tx_data); else passed++;
        @(posedge clk);
        #2 rst = 1'b0;
        vc = valid_cycles;
        sc = start_cnt;
        wait_cycles(50);
        total++; if (valid_cycles != vc) $display("FAIL postrst_valid: got %0d valid cycles want 0", valid_cycles - vc); else passed++;
        total++; if (start_cnt != sc) $display("FAIL postrst_start: got %0d starts want 0", start_cnt - sc); else passed++;
    endtask

    task automatic test_full_dump();
        int base, sb, db, rb, re0, rbe0, dna0, bad0, mism, n;
        bit to;
        fill_pattern();
        build_expected();
        bp_en = 1'b0;
        base = byte_q.size();
        sb = start_cnt; db = done_cnt; rb = ren_cnt;
        re0 = raddr_err; rbe0 = ren_busy_err; dna0 = done_noacc_err; bad0 = busy_after_done_err;
        pulse_trigger();
        wait_cycles(100);
        total++; if (busy !== 1'b1) $display("FAIL full_busy_wait: got %b want 1", busy); else passed++;
        pulse_trigger(); // during WAIT: must be ignored
        n = 0;
        while (byte_q.size() < base + 10 && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        pulse_trigger(); // during SEND: must be ignored
        wait_done(db, 20000, to);
        total++; if (to) $display("FAIL full_timeout: got no done want done"); else passed++;
        @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL full_busy_after_done: got %b want 0", busy); else passed++;
        wait_cycles(20);
        total++; if (byte_q.size() - base != NB) $display("FAIL full_count: got %0d want %0d", byte_q.size() - base, NB); else passed++;
        mism = 0;
        for (int i = 0; i < NB; i++) if (byte_q[base+i] !== exp_q[i]) mism++;
        total++; if (mism != 0) $display("FAIL full_stream: got %0d mismatching bytes want 0", mism); else passed++;
        total++; if ({byte_q[base+3], byte_q[base+2], byte_q[base+1], byte_q[base]} !== 32'hA500_0000)
            $display("FAIL full_first4: got %h %h %h %h want 00 00 00 a5", byte_q[base], byte_q[base+1], byte_q[base+2], byte_q[base+3]);
        else passed++;
        total++; if ({byte_q[base+NB-1], byte_q[base+NB-2], byte_q[base+NB-3], byte_q[base+NB-4]} !== 32'hA500_07FF)
            $display("FAIL full_last4: got %h %h %h %h want ff 07 00 a5", byte_q[base+NB-4], byte_q[base+NB-3], byte_q[base+NB-2], byte_q[base+NB-1]);
        else passed++;
        total++; if (start_cnt - sb != 1) $display("FAIL full_starts: got %0d want 1", start_cnt - sb); else passed++;
        total++; if (done_cnt - db != 1) $display("FAIL full_done_pulse: got %0d done cycles want 1", done_cnt - db); else passed++;
        total++; if (ren_cnt - rb != NW) $display("FAIL full_reads: got %0d want %0d", ren_cnt - rb, NW); else passed++;
        total++; if (raddr_err != re0) $display("FAIL full_raddr_seq: got %0d errors want 0", raddr_err - re0); else passed++;
        total++; if (ren_busy_err != rbe0) $display("FAIL full_ren_busy: got %0d errors want 0", ren_busy_err - rbe0); else passed++;
        total++; if (done_noacc_err != dna0) $display("FAIL full_done_acc: got %0d errors want 0", done_noacc_err - dna0); else passed++;
        total++; if (busy_after_done_err != bad0) $display("FAIL full_busy_fall: got %0d errors want 0", busy_after_done_err - bad0); else passed++;
        total++; if (first_ren_cyc - last_start_cyc != NW + 1) $display("FAIL full_arm_lat: got %0d want %0d", first_ren_cyc - last_start_cyc, NW + 1); else passed++;
        total++; if (first_valid_cyc - first_ren_cyc != 2) $display("FAIL full_read_lat: got %0d want 2", first_valid_cyc - first_ren_cyc); else passed++;
        total++; if (last_done_cyc - first_ren_cyc != NW * (2 + BPW) - 1)
            $display("FAIL full_throughput: got %0d want %0d", last_done_cyc - first_ren_cyc, NW * (2 + BPW) - 1);
        else passed++;
    endtask

    task automatic test_backpressure();
        int base, sb, db, se0, re0, mism;
        bit to;
        fill_random();
        build_expected();
        base = byte_q.size();
        sb = start_cnt; db = done_cnt; se0 = stab_err; re0 = raddr_err;
        bp_en = 1'b1;
        pulse_trigger();
        wait_done(db, 60000, to);
        bp_en = 1'b0;
        wait_cycles(5);
        total++; if (to) $display("FAIL bp_timeout: got no done want done"); else passed++;
        total++; if (byte_q.size() - base != NB) $display("FAIL bp_count: got %0d want %0d", byte_q.size() - base, NB); else passed++;
        mism = 0;
        for (int i = 0; i < NB; i++) if (byte_q[base+i] !== exp_q[i]) mism++;
        total++; if (mism != 0) $display("FAIL bp_stream: got %0d mismatching bytes want 0", mism); else passed++;
        total++; if (stab_err != se0) $display("FAIL bp_stable: got %0d violations want 0", stab_err - se0); else passed++;
        total++; if (done_cnt - db != 1) $display("FAIL bp_done: got %0d want 1", done_cnt - db); else passed++;
        total++; if (start_cnt - sb != 1) $display("FAIL bp_starts: got %0d want 1", start_cnt - sb); else passed++;
        total++; if (raddr_err != re0) $display("FAIL bp_raddr_seq: got %0d errors want 0", raddr_err - re0); else passed++;
    endtask

    task automatic test_back_to_back();
        int base, sb, db, n, mism;
        bit to;
        fill_random();
        build_expected();
        bp_en = 1'b0;
        sb = start_cnt; db = done_cnt;
        pulse_trigger();
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else passed++;
        trigger = 1'b1; // lands in the done cycle, must be ignored
        #0;
        total++; if (start !== 1'b0) $display("FAIL b2b_ignore_done_cycle: got start %b want 0", start); else passed++;
        @(negedge clk);
        #1;
        total++; if (start !== 1'b1) $display("FAIL b2b_accept_idle: got start %b want 1", start); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy); else passed++;
        @(posedge clk);
        #2 trigger = 1'b0;
        base = byte_q.size();
        wait_done(db + 1, 20000, to);
        wait_cycles(5);
        total++; if (to) $display("FAIL b2b_timeout: got no second done want done"); else passed++;
        total++; if (start_cnt - sb != 2) $display("FAIL b2b_starts: got %0d want 2", start_cnt - sb); else passed++;
        total++; if (last_start_cyc != first_ren_cyc - (NW + 1)) $display("FAIL b2b_arm_lat: got %0d want %0d", first_ren_cyc - last_start_cyc, NW + 1); else passed++;
        total++; if (done_cnt - db != 2) $display("FAIL b2b_dones: got %0d want 2", done_cnt - db); else passed++;
        total++; if (byte_q.size() - base != NB) $display("FAIL b2b_count: got %0d want %0d", byte_q.size() - base, NB); else passed++;
        mism = 0;
        for (int i = 0; i < NB; i++) if (byte_q[base+i] !== exp_q[i]) mism++;
        total++; if (mism != 0) $display("FAIL b2b_stream: got %0d mismatching bytes want 0", mism); else passed++;
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
